im_bank_store: RTL and testbench

IM_BANK_STORE -- requirements
Module: im_bank_store

---
 rtl/im_bank_store_pkg.sv | 32 +++
 rtl/im_sram_bank.sv | 39 +++
 rtl/im_bank_store.sv | 222 ++++++++++++++++++++++
 tb/tb_im_bank_store.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_bank_store_pkg.sv
// -----------------------------------------------------------------------------
// im_bank_store_pkg
//   Shared definitions for the banked fold-word store:
//   - state_t              : control FSM states (IDLE / STREAM / DRAIN)
//   - FIFO_DEPTH           : number of response-FIFO entries
//   - num_banks()          : how many SRAM banks a fold word is split across
//   - bank_width()         : width of bank k (the last bank takes the remainder)
// -----------------------------------------------------------------------------
package im_bank_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int num_banks(input int fold_width, input int sram_width);
    return (fold_width + sram_width - 1) / sram_width;
  endfunction

  function automatic int bank_width(input int k, input int fold_width, input int sram_width);
    int nb;
    nb = num_banks(fold_width, sram_width);
    if (k == nb - 1) begin
      return fold_width - (nb - 1) * sram_width;
    end
    return sram_width;
  endfunction

endpackage

// File: rtl/im_sram_bank.sv
// -----------------------------------------------------------------------------
// im_sram_bank
//   Single-port SRAM bank model with active-low controls and a one-cycle read.
//   This is the one place to swap in a technology macro.
//   Ports:
//     clk  : clock
//     ceb  : chip enable, active low (bank idle when high)
//     web  : write enable, active low (read when high and ceb low)
//     addr : word address
//     d    : write data
//     q    : read data, valid the cycle after a read is issued; holds otherwise
// -----------------------------------------------------------------------------
module im_sram_bank #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 864,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  ceb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; q only updates on an enabled read.
  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) begin
        mem[addr] <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/im_bank_store.sv
// -----------------------------------------------------------------------------
// im_bank_store
//   Fold-word store split across NUM_BANKS SRAM banks, with single reads,
//   burst (stream) reads of consecutive addresses and a 2-entry response FIFO.
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     wr_valid/wr_ready        : write request (wr_addr, wr_data, wr_bank_en)
//     rd_valid/rd_ready        : single read request (rd_addr)
//     stream_start/base/len    : start a burst read of len words from base
//     stream_busy              : burst in progress (STREAM or DRAIN)
//     stream_done              : one-cycle pulse when a burst has fully drained
//     dout_valid/dout_ready    : read-response stream (dout)
//     dbg_state                : current control FSM state
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. valid must not depend on ready. dout and dout_valid hold
//   steady while dout_valid && !dout_ready. rd_ready/wr_ready may depend
//   combinationally on the current inputs (write priority, stream start,
//   response back-pressure).
// -----------------------------------------------------------------------------
module im_bank_store
  import im_bank_store_pkg::*;
#(
  parameter int FOLD_WIDTH = 500,
  parameter int SRAM_WIDTH = 144,
  parameter int DEPTH      = 864,
  localparam int SRAM_ADDR_WIDTH = $clog2(DEPTH),
  localparam int NUM_BANKS       = num_banks(FOLD_WIDTH, SRAM_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [FOLD_WIDTH-1:0]      wr_data,
  input  logic [NUM_BANKS-1:0]       wr_bank_en,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       stream_start,
  input  logic [SRAM_ADDR_WIDTH-1:0] stream_base,
  input  logic [SRAM_ADDR_WIDTH:0]   stream_len,
  output logic                       stream_busy,
  output logic                       stream_done,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FOLD_WIDTH-1:0]      dout,
  output state_t                     dbg_state
);

  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_LAST = SRAM_ADDR_WIDTH'(DEPTH - 1);
  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [SRAM_ADDR_WIDTH:0]   REM_ONE   = 1;

  // ---------------------------------------------------------------------------
  // Control signals
  // ---------------------------------------------------------------------------
  state_t                     state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] stream_addr_q, stream_addr_d, stream_addr_inc;
  logic [SRAM_ADDR_WIDTH:0]   stream_rem_q, stream_rem_d;
  logic                       stream_done_q, done_d;

  logic                       wr_fire;
  logic                       rd_issue;
  logic                       stream_issue;
  logic                       any_issue;
  logic                       credit_ok;
  logic                       pop;
  logic [2:0]                 occ_after;

  // Response FIFO
  logic                       in_flight_q;
  logic [1:0]                 fifo_count_q;
  logic                       fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [FOLD_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];

  // Bank interface
  logic [NUM_BANKS-1:0]       bank_ceb;
  logic                       bank_web;
  logic [SRAM_ADDR_WIDTH-1:0] bank_addr;
  logic [FOLD_WIDTH-1:0]      rd_word;

  // Writes always win; ready only drops while reset is held.
  assign wr_ready = !rst;
  assign wr_fire  = wr_valid && wr_ready;

  assign dout_valid = (fifo_count_q != 2'd0);
  assign dout       = fifo_mem[fifo_rd_ptr_q];
  assign pop        = dout_valid && dout_ready;

  // Occupancy the FIFO will have once this cycle's pop and the in-flight
  // word land. Counting the pop keeps back-to-back reads at one per cycle;
  // a read issued now lands next cycle, so at most 2 entries ever exist.
  assign occ_after = {1'b0, fifo_count_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign credit_ok = (occ_after < 3'd2);

  assign stream_addr_inc = (stream_addr_q == ADDR_LAST) ? '0 : stream_addr_q + ADDR_ONE;

  assign rd_issue  = rd_valid && rd_ready;
  assign any_issue = rd_issue || stream_issue;

  assign stream_busy = (state_q != ST_IDLE);
  assign stream_done = stream_done_q;
  assign dbg_state   = state_q;

  // ---------------------------------------------------------------------------
  // FSM next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    stream_addr_d = stream_addr_q;
    stream_rem_d  = stream_rem_q;
    done_d        = 1'b0;
    rd_ready      = 1'b0;
    stream_issue  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          // A stream start claims the cycle; a concurrent single read waits.
          if (stream_start) begin
            if (stream_len != '0) begin
              state_d       = ST_STREAM;
              stream_addr_d = stream_base;
              stream_rem_d  = stream_len;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            rd_ready = !wr_fire && credit_ok;
          end
        end
        ST_STREAM: begin
          if (!wr_fire && credit_ok) begin
            stream_issue  = 1'b1;
            stream_addr_d = stream_addr_inc;
            stream_rem_d  = stream_rem_q - REM_ONE;
            if (stream_rem_q == REM_ONE) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((fifo_count_q == 2'd0) && !in_flight_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bank controls: all banks share one address; unselected banks stay idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_web = !wr_fire;
    if (wr_fire) begin
      bank_addr = wr_addr;
      bank_ceb  = ~wr_bank_en;
    end else begin
      bank_addr = stream_issue ? stream_addr_q : rd_addr;
      bank_ceb  = {NUM_BANKS{~any_issue}};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      stream_addr_q <= '0;
      stream_rem_q  <= '0;
      stream_done_q <= 1'b0;
      in_flight_q   <= 1'b0;
      fifo_count_q  <= 2'd0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stream_addr_q <= stream_addr_d;
      stream_rem_q  <= stream_rem_d;
      stream_done_q <= done_d;
      in_flight_q   <= any_issue;
      fifo_count_q  <= fifo_count_q + {1'b0, in_flight_q} - {1'b0, pop};
      if (in_flight_q) begin
        fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fifo_count_q.
  always_ff @(posedge clk) begin
    if (in_flight_q) begin
      fifo_mem[fifo_wr_ptr_q] <= rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank array
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam int W   = bank_width(k, FOLD_WIDTH, SRAM_WIDTH);
    localparam int LSB = k * SRAM_WIDTH;
    im_sram_bank #(
      .WIDTH (W),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk  (clk),
      .ceb  (bank_ceb[k]),
      .web  (bank_web),
      .addr (bank_addr),
      .d    (wr_data[LSB +: W]),
      .q    (rd_word[LSB +: W])
    );
  end

endmodule

// File: tb/tb_im_bank_store.sv
module tb_im_bank_store;
  import im_bank_store_pkg::*;

  localparam int FW    = 500;
  localparam int SW    = 144;
  localparam int DEPTH = 864;
  localparam int AW    = 10;
  localparam int NB    = 4;

  logic          clk, rst;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic [NB-1:0] wr_bank_en;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          stream_start;
  logic [AW-1:0] stream_base;
  logic [AW:0]   stream_len;
  logic          stream_busy, stream_done;
  logic          dout_valid, dout_ready;
  logic [FW-1:0] dout;
  state_t        dbg_state;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] model_mem [DEPTH];
  logic [FW-1:0] mon_exp;
  int vectors = 0;
  int errors  = 0;

  im_bank_store dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bank_en(wr_bank_en),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .stream_start(stream_start), .stream_base(stream_base), .stream_len(stream_len),
    .stream_busy(stream_busy), .stream_done(stream_done),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %h, expected no word", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          errors++;
          $display("FAIL dout_data: got %h expected %h", dout, mon_exp);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_word();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    return t[FW-1:0];
  endfunction

  task automatic do_write(input int a, input logic [FW-1:0] d, input logic [NB-1:0] en);
    wr_valid   = 1'b1;
    wr_addr    = AW'(a);
    wr_data    = d;
    wr_bank_en = en;
    for (int b = 0; b < FW; b++) if (en[b / SW]) model_mem[a][b] = d[b];
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [FW-1:0] expect_d, output bit ok);
    ok       = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = AW'(a);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rd_ready) begin
        exp_q.push_back(expect_d);
        ok = 1'b1;
      end
      tick();
    end
    rd_valid = 1'b0;
  endtask

  task automatic start_stream(input int base, input int len);
    stream_start = 1'b1;
    stream_base  = AW'(base);
    stream_len   = (AW+1)'(len);
    tick();
    stream_start = 1'b0;
  endtask

  task automatic push_stream(input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(base + i) % DEPTH]);
  endtask

  // Run until everything expected has come out and the FSM is idle, then a
  // few more cycles so any late or repeated stream_done pulse is counted.
  task automatic settle(input int budget, output bit ok, output int pulses);
    int extra;
    ok = 1'b0; pulses = 0; extra = 0;
    for (int i = 0; i < budget && extra < 3; i++) begin
      @(negedge clk);
      if (stream_done) pulses++;
      if (ok) extra++;
      else if (exp_q.size() == 0 && !stream_busy && !dout_valid) ok = 1'b1;
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b expected 0", dout_valid); end
    vectors++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", stream_busy); end
    vectors++; if (stream_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", stream_done); end
    vectors++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready: got %b expected 0", rd_ready); end
    vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b expected 0", wr_ready); end
    vectors++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wr_ready: got %b expected 1", wr_ready); end
    vectors++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_rd_ready: got %b expected 1", rd_ready); end
    tick();
  endtask

  task automatic test_write_read();
    logic [503:0] t;
    logic [FW-1:0] pat, rw;
    bit ok;
    int pulses;
    for (int i = 0; i < 63; i++) t[i*8 +: 8] = 8'hA5;
    pat = t[FW-1:0];
    do_write(5, pat, 4'hF);
    rd_valid = 1'b1;
    rd_addr  = AW'(5);
    @(negedge clk);
    vectors++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL wr_rd_ready: got %b expected 1", rd_ready); end
    exp_q.push_back(pat);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", dout_valid); end
    tick();
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL latency_2: got %b expected 1", dout_valid); end
    vectors++; if (dout !== pat) begin errors++; $display("FAIL pattern_a5: got %h expected %h", dout, pat); end
    tick();
    rw = rand_word();
    do_write(9, rw, 4'hF);
    do_read(9, model_mem[9], ok);
    vectors++; if (!ok) begin errors++; $display("FAIL rd9_accept: got 0 expected 1"); end
    settle(30, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL rd9_drain: got 0 expected 1"); end
  endtask

  task automatic test_bank_enable();
    logic [FW-1:0] ones, expd;
    bit ok;
    int pulses;
    ones = '1;
    expd = '1;
    expd[287:144] = '0;
    do_write(7, ones, 4'hF);
    do_write(7, '0, 4'b0010);
    do_read(7, expd, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL bank_en_accept: got 0 expected 1"); end
    settle(30, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL bank_en_drain: got 0 expected 1"); end
  endtask

  task automatic test_zero_len();
    start_stream(3, 0);
    @(negedge clk);
    vectors++; if (stream_done !== 1'b1) begin errors++; $display("FAIL zero_len_done: got %b expected 1", stream_done); end
    vectors++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy: got %b expected 0", stream_busy); end
    tick();
    @(negedge clk);
    vectors++; if (stream_done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse: got %b expected 0", stream_done); end
    tick();
  endtask

  task automatic test_start_with_read();
    bit ok;
    int pulses;
    do_write(10, rand_word(), 4'hF);
    do_write(20, rand_word(), 4'hF);
    exp_q.push_back(model_mem[10]);
    stream_start = 1'b1; stream_base = AW'(10); stream_len = (AW+1)'(1);
    rd_valid = 1'b1; rd_addr = AW'(20);
    @(negedge clk);
    vectors++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL start_rd_ready: got %b expected 0", rd_ready); end
    tick();
    stream_start = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    vectors++; if (stream_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", stream_busy); end
    tick();
    settle(40, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL start_drain: got 0 expected 1"); end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL start_done_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_stream_wrap();
    bit ok;
    int pulses;
    do_write(862, rand_word(), 4'hF);
    do_write(863, rand_word(), 4'hF);
    do_write(0, rand_word(), 4'hF);
    do_write(1, rand_word(), 4'hF);
    exp_q.push_back(model_mem[862]);
    exp_q.push_back(model_mem[863]);
    exp_q.push_back(model_mem[0]);
    exp_q.push_back(model_mem[1]);
    start_stream(862, 4);
    settle(40, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL wrap_drain: got 0 expected 1"); end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_stall();
    bit ok;
    int pulses;
    for (int i = 0; i < 8; i++) do_write(100 + i, rand_word(), 4'hF);
    dout_ready = 1'b0;
    push_stream(100, 8);
    start_stream(100, 8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b expected 1", c, dout_valid); end
        vectors++; if (dout !== model_mem[100]) begin errors++; $display("FAIL stall_hold c%0d: got %h expected %h", c, dout, model_mem[100]); end
      end
      if (c == 9) begin
        vectors++; if (dbg_state !== ST_STREAM) begin errors++; $display("FAIL stall_state: got %0d expected 1", dbg_state); end
      end
      tick();
    end
    dout_ready = 1'b1;
    settle(80, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL stall_drain: got 0 expected 1"); end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL stall_done_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_write_during_stream();
    bit ok;
    int pulses, w;
    logic [FW-1:0] nv;
    for (int i = 0; i < 6; i++) do_write(200 + i, rand_word(), 4'hF);
    push_stream(200, 6);
    start_stream(200, 6);
    w = 0; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0 && w < 6) begin
        wr_valid = 1'b1; wr_addr = AW'(300 + w); wr_data = rand_word(); wr_bank_en = 4'hF;
        model_mem[300 + w] = wr_data;
        w++;
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (stream_done) pulses++;
      tick();
    end
    wr_valid = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL wds_words_left: got %0d expected 0", exp_q.size()); end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL wds_done_pulses: got %0d expected 1", pulses); end
    do_read(300, model_mem[300], ok);
    do_read(305, model_mem[305], ok);
    // Write and read the same address in one cycle: read must see new data.
    do_write(50, rand_word(), 4'hF);
    nv = rand_word();
    wr_valid = 1'b1; wr_addr = AW'(50); wr_data = nv; wr_bank_en = 4'hF;
    rd_valid = 1'b1; rd_addr = AW'(50);
    @(negedge clk);
    vectors++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL same_addr_rd_ready: got %b expected 0", rd_ready); end
    tick();
    wr_valid = 1'b0;
    model_mem[50] = nv;
    @(negedge clk);
    vectors++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL deferred_rd_ready: got %b expected 1", rd_ready); end
    if (rd_ready) exp_q.push_back(nv);
    tick();
    rd_valid = 1'b0;
    settle(40, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL wds_drain: got 0 expected 1"); end
  endtask

  task automatic test_reset_in_drain();
    bit ok, seen;
    int pulses;
    do_write(400, rand_word(), 4'hF);
    do_write(401, rand_word(), 4'hF);
    dout_ready = 1'b0;
    push_stream(400, 2);
    start_stream(400, 2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == ST_DRAIN) seen = 1'b1;
      else tick();
    end
    vectors++; if (!seen) begin errors++; $display("FAIL drain_reached: got 0 expected 1"); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL drain_rst_valid: got %b expected 0", dout_valid); end
    vectors++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL drain_rst_busy: got %b expected 0", stream_busy); end
    exp_q.delete();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stream_done) pulses++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stream_done) pulses++;
      tick();
    end
    vectors++; if (pulses != 0) begin errors++; $display("FAIL drain_rst_done: got %0d expected 0", pulses); end
    do_read(401, model_mem[401], ok);
    vectors++; if (!ok) begin errors++; $display("FAIL post_drain_rd: got 0 expected 1"); end
    settle(30, ok, pulses);
    vectors++; if (!ok) begin errors++; $display("FAIL post_drain_drain: got 0 expected 1"); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_bank_en = '0;
    rd_valid = 1'b0; rd_addr = '0;
    stream_start = 1'b0; stream_base = '0; stream_len = '0;
    dout_ready = 1'b1;
    #2 rst = 1'b1;
    test_reset();
    test_write_read();
    test_bank_enable();
    test_zero_len();
    test_start_with_read();
    test_stream_wrap();
    test_stall();
    test_write_during_stream();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
